// File: rtl/expipe_pkg.sv
// Execution-pipe shared types: CDB payload layout used by EU queues, the CDB mux and the ROB.
// Latency: n/a (types only).
// Backpressure: n/a.
package expipe_pkg;

    localparam int XLEN        = 64;
    localparam int ROB_IDX_LEN = 6;
    localparam int EXCEPT_LEN  = 4;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic [XLEN-1:0]        value;
        logic                   except_raised;
        logic [EXCEPT_LEN-1:0]  except_code;
    } cdb_data_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Circular-buffer head/tail/count bookkeeping with full/empty flags; flush clears everything.
// Latency: pointer and count updates are registered, flags derive combinationally from count.
// Backpressure: caller must gate push with !full and pop with !empty.
module fifo_ptr_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] head,
    output logic [PW-1:0] tail,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_tx_buffer.sv
// In-order result queue between one EU and the CDB arbiter; optional CDB_TX_BYPASS_EN adds an empty-queue bypass.
// Latency: 1 cycle EU push to cdb_valid_o (0 cycles when bypass is built in and the queue is empty).
// Backpressure: eu_ready_o drops when full or flushing; the head request is held stable until granted.
module cdb_tx_buffer
    import expipe_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   eu_valid_i,
    output logic                   eu_ready_o,
    input  logic [ROB_IDX_LEN-1:0] eu_rob_idx_i,
    input  logic [XLEN-1:0]        eu_value_i,
    input  logic                   eu_except_raised_i,
    input  logic [EXCEPT_LEN-1:0]  eu_except_code_i,
    output logic                   cdb_valid_o,
    input  logic                   cdb_ready_i,
    output cdb_data_t              cdb_data_o,
    output logic [CW-1:0]          count_o
);

    cdb_data_t       mem [DEPTH];
    cdb_data_t       eu_data;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    always_comb begin
        eu_data               = '0;
        eu_data.rob_idx       = eu_rob_idx_i;
        eu_data.value         = eu_value_i;
        eu_data.except_raised = eu_except_raised_i;
        eu_data.except_code   = eu_except_code_i;
    end

    assign eu_ready_o = !full && !flush_i;

`ifdef CDB_TX_BYPASS_EN
    logic bypass;

    // An empty queue forwards the incoming result; a granted forward is never written.
    assign bypass      = empty && eu_valid_i && !flush_i;
    assign cdb_valid_o = (!empty || eu_valid_i) && !flush_i;
    assign cdb_data_o  = bypass ? eu_data : mem[head];
    assign push        = eu_valid_i && eu_ready_o && !(bypass && cdb_ready_i);
    assign pop         = cdb_valid_o && cdb_ready_i && !bypass;
`else
    assign cdb_valid_o = !empty && !flush_i;
    assign cdb_data_o  = mem[head];
    assign push        = eu_valid_i && eu_ready_o;
    assign pop         = cdb_valid_o && cdb_ready_i;
`endif

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush   (flush_i),
        .push    (push),
        .pop     (pop),
        .head    (head),
        .tail    (tail),
        .count   (count_o),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[tail] <= eu_data;
        end
    end

endmodule
